// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, the
// controller state enum and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // True when the access cannot be served; size 3 is reserved and always faults.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'd0);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane handling for the load/store unit (combinational).
//   word_i     : 32-bit memory word (buffered copy)
//   size_i     : access size, offset_i : byte offset within the word
//   unsigned_i : zero-extend (1) or sign-extend (0) loads
//   wdata_i    : right-justified store data
//   ext_o      : addressed lane, extended to 32 bits
//   merge_o    : word_i with the addressed lane replaced by store data
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection: offset 0 is the most significant byte/half.
  always_comb begin
    byte_lane = 8'h00;
    case (offset_i)
      2'd0: byte_lane = word_i[31:24];
      2'd1: byte_lane = word_i[23:16];
      2'd2: byte_lane = word_i[15:8];
      2'd3: byte_lane = word_i[7:0];
      default: byte_lane = 8'h00;
    endcase
    half_lane = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  // Load extension.
  always_comb begin
    ext_o = word_i;
    case (size_i)
      SZ_BYTE: ext_o = unsigned_i ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: ext_o = unsigned_i ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ext_o = word_i;
    endcase
  end

  // Store merge: read-modify-write for sub-word stores, pass-through for words.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd0: merge_o[31:24] = wdata_i[7:0];
          2'd1: merge_o[23:16] = wdata_i[7:0];
          2'd2: merge_o[15:8]  = wdata_i[7:0];
          2'd3: merge_o[7:0]   = wdata_i[7:0];
          default: merge_o = word_i;
        endcase
      end
      SZ_HALF: begin
        if (offset_i[1]) merge_o[15:0]  = wdata_i[15:0];
        else             merge_o[31:16] = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word access at a time from the core,
// faults misaligned accesses, performs read-modify-write for sub-word stores
// against a word-wide memory with asynchronous read, and returns a one-cycle
// response.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata: access description
//   resp_valid/rdata/misalign      : one-cycle completion, data zero unless valid
//   mem_we/mem_a/mem_d/mem_q       : word-addressed data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  input  logic [31:0]       mem_q
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              mis_q;
  logic [31:0]       buf_q;

  logic [31:0]       lane_ext;
  logic [31:0]       lane_merge;
  logic              req_mis;

  // Address bits above the memory window are deliberately ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  // Controller and request/buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            mis_q   <= req_mis;
            if (req_mis)                            state_q <= RESP;
            else if (req_we && req_size == SZ_WORD) state_q <= WRITE;
            else                                    state_q <= READ;
          end
        end
        READ: begin
          buf_q   <= mem_q;
          state_q <= we_q ? WRITE : RESP;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  lsu_lane u_lane (
    .word_i     (buf_q),
    .size_i     (size_q),
    .offset_i   (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .ext_o      (lane_ext),
    .merge_o    (lane_merge)
  );

  // Outputs decode the state register; rst gates them so nothing leaks during
  // the first reset cycle before the registers clear.
  assign req_ready     = (state_q == IDLE) && !rst;
  assign resp_valid    = (state_q == RESP) && !rst;
  assign resp_misalign = resp_valid && mis_q;
  assign resp_rdata    = (resp_valid && !we_q && !mis_q) ? lane_ext : 32'h0;
  assign mem_we        = (state_q == WRITE) && !rst;
  assign mem_d         = mem_we ? lane_merge : 32'h0;
  assign mem_a         = rst ? '0 : addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses checked against a byte-array reference of memory.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misalign;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic [31:0]       mem_q;

  logic [31:0] mem [NWORDS];
  logic [7:0]  rmem [NWORDS*4];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_pulses = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  // Data memory: asynchronous read, synchronous write.
  assign mem_q = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
  always @(negedge clk) if (mem_we) we_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed, big-endian) ----------
  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd2) return (a % 4) != 0;
    if (sz == 2'd1) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic int ref_lat(input logic we, input logic [1:0] sz, input logic [31:0] a);
    if (ref_mis(sz, a)) return 1;
    if (!we)            return 2;
    return (sz == 2'd2) ? 2 : 3;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {rmem[idx*4], rmem[idx*4+1], rmem[idx*4+2], rmem[idx*4+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int b;
    logic [31:0] v;
    b = int'(a % (NWORDS*4));
    if (sz == 2'd0) begin
      v = {24'h0, rmem[b]};
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = {16'h0, rmem[b], rmem[b+1]};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {rmem[b], rmem[b+1], rmem[b+2], rmem[b+3]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = int'(a % (NWORDS*4));
    if (sz == 2'd0) rmem[b] = wd[7:0];
    else if (sz == 2'd1) begin
      rmem[b] = wd[15:8]; rmem[b+1] = wd[7:0];
    end else begin
      rmem[b] = wd[31:24]; rmem[b+1] = wd[23:16]; rmem[b+2] = wd[15:8]; rmem[b+3] = wd[7:0];
    end
  endtask

  // One complete access with full response checking.
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        e_mis;
    int          e_lat;
    logic [31:0] e_rd;
    int          pulses0;
    int          lat;
    logic        seen;
    logic [31:0] got_rd;
    logic        got_mis;
    logic [31:0] got_a;
    e_mis = ref_mis(sz, a);
    e_lat = ref_lat(we, sz, a);
    e_rd  = (we || e_mis) ? 32'h0 : ref_load(sz, uns, a);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    pulses0 = we_pulses;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    seen = 1'b0; lat = 0; got_rd = 32'h0; got_mis = 1'b0; got_a = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      if (resp_valid) begin
        seen = 1'b1; lat = c; got_rd = resp_rdata; got_mis = resp_misalign;
        got_a = 32'(mem_a);
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_misalign"}, 32'(got_mis), 32'(e_mis));
    chk({tag, "_rdata"}, got_rd, e_rd);
    chk({tag, "_mem_a"}, got_a, 32'((a >> 2) % NWORDS));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {30'h0, resp_valid, resp_misalign}, 32'h0);
    chk({tag, "_rdata_idle"}, resp_rdata, 32'h0);
    @(negedge clk);
    chk({tag, "_we_pulses"}, 32'(we_pulses - pulses0), (we && !e_mis) ? 32'd1 : 32'd0);
    if (we && !e_mis) ref_store(sz, a, wd);
  endtask

  // Reset hits an access after `hold` cycles past accept; nothing may complete.
  task automatic reset_mid(input string tag, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input int hold);
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = 1'b0;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < hold; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rst_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rst_mem_a"}, 32'(mem_a), 32'd0);
    chk({tag, "_rst_mem_d"}, mem_d, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || mem_we) seen++;
      @(negedge clk);
    end
    chk({tag, "_no_activity"}, 32'(seen), 32'd0);
    chk({tag, "_mem_kept"}, mem[(a >> 2) % NWORDS], ref_word(int'((a >> 2) % NWORDS)));
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    logic        rw;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_outs", {29'h0, resp_valid, resp_misalign, mem_we}, 32'h0);
    chk("reset_mem_a", 32'(mem_a), 32'd0);
    chk("reset_mem_d", mem_d, 32'h0);
    chk("reset_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill memory with random words through the unit itself.
    for (int i = 0; i < int'(NWORDS); i++) access("fill", 1'b1, 2'd2, 1'b0, 32'(i*4), $urandom);

    // Word store then load.
    access("w_st", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    access("w_ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("w_mem", mem[4], 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads.
    access("b_pre", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    access("b_st", 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
    chk("b_mem", mem[8], 32'h11AA3344);
    access("b_lds", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    access("b_ldu", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);

    // Halfword loads, both lanes.
    access("h_pre", 1'b1, 2'd2, 1'b0, 32'h30, 32'h80017FFF);
    access("h_ld0", 1'b0, 2'd1, 1'b0, 32'h30, 32'h0);
    access("h_ld2", 1'b0, 2'd1, 1'b0, 32'h32, 32'h0);
    access("h_st2", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF);
    chk("h_mem", mem[12], 32'h8001BEEF);

    // Misaligned word store leaves memory alone.
    access("mis_w", 1'b1, 2'd2, 1'b0, 32'h13, 32'h12345678);
    chk("mis_mem", mem[4], 32'hDEADBEEF);
    access("mis_sz3", 1'b0, 2'd3, 1'b0, 32'h14, 32'h0);

    // Upper address bits alias onto the memory window.
    access("alias", 1'b0, 2'd2, 1'b0, 32'hFFFF_FF10, 32'h0);

    // Reset in WRITE of a word store and in READ of a byte store.
    reset_mid("rst_wr", 1'b1, 2'd2, 32'h44, 32'h5555AAAA, 1);
    reset_mid("rst_rd", 1'b1, 2'd0, 32'h49, 32'h000000CC, 1);
    reset_mid("rst_rmw", 1'b1, 2'd1, 32'h4C, 32'h00001234, 2);

    // Back-to-back loads with req_valid held.
    @(negedge clk);
    chk("b2b_ready0", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h21;
    chk("b2b_ready_c1", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp1", {31'h0, resp_valid}, 32'd1);
    chk("b2b_ready_c2", 32'(req_ready), 32'd0);
    chk("b2b_rdata1", resp_rdata, ref_load(2'd2, 1'b0, 32'h10));
    @(posedge clk); #1;
    chk("b2b_ready_c3", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_ready_c4", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp2", {31'h0, resp_valid}, 32'd1);
    chk("b2b_rdata2", resp_rdata, ref_load(2'd0, 1'b1, 32'h21));
    @(posedge clk); #1;

    // Random traffic, mostly aligned.
    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom_range(0, 3));
      if (rs == 2'd3 && $urandom_range(0, 3) != 0) rs = 2'd2;
      rw = 1'($urandom);
      ra = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      access("rnd", rw, rs, 1'($urandom), ra, $urandom);
    end

    for (int i = 0; i < int'(NWORDS); i++) chk("final_mem", mem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width toward data memory.
REQ-002 SHALL have input clk, 1 bit: clock, all state updates on rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input req_valid, 1 bit: core presents an access.
REQ-005 SHALL have output req_ready, 1 bit: unit accepts the access this cycle.
REQ-006 SHALL have input req_we, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have input req_size, 2 bits: 0 byte, 1 halfword, 2 word; 3 reserved.
REQ-008 SHALL have input req_unsigned, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have input req_addr, 32 bits: byte address.
REQ-010 SHALL have input req_wdata, 32 bits: store data, right-justified.
REQ-011 SHALL have output resp_valid, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have output resp_rdata, 32 bits: extended load data, 0 for stores.
REQ-013 SHALL have output resp_misalign, 1 bit: access faulted, qualified by resp_valid.
REQ-014 SHALL have outputs mem_we (1 bit), mem_a (ADDR_W bits), mem_d (32 bits), and input mem_q (32 bits, asynchronous read of mem_a).

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL latch we/size/unsigned/addr/wdata on req_valid && req_ready.
REQ-017 SHALL flag misalign when size=1 && addr[0], size=2 && addr[1:0]!=0, or size=3; a flagged access goes IDLE->RESP, no memory write.
REQ-018 SHALL route aligned word store IDLE->WRITE->RESP; aligned load IDLE->READ->RESP; aligned byte/half store IDLE->READ->WRITE->RESP.
REQ-019 SHALL give latency from accept edge to resp_valid: misalign 1, load 2, word store 2, sub-word store 3 cycles.
REQ-020 SHALL drive mem_a = latched addr[ADDR_W+1:2] in all states; addr[31:ADDR_W+2] ignored.
REQ-021 SHALL capture mem_q into a 32-bit word buffer at the end of READ.
REQ-022 SHALL assert mem_we only in WRITE and only while rst=0, exactly one cycle per store.
REQ-023 SHALL use big-endian lanes: byte offset 0 = bits 31:24, halfword offset 0 = bits 31:16.
REQ-024 SHALL drive mem_d in WRITE: word store = wdata; sub-word store = buffer with addressed lane replaced by wdata[7:0] or wdata[15:0].
REQ-025 SHALL extract the addressed lane from the buffer for loads and extend per req_unsigned to 32 bits, held on resp_rdata during RESP.
REQ-026 SHALL return RESP->IDLE unconditionally; resp_valid high exactly one cycle; no back-pressure.
REQ-027 SHALL hold resp_rdata = 0 and resp_misalign = 0 whenever resp_valid = 0.

Reset
REQ-028 SHALL on rst force state IDLE, clear latched request and buffer, and discard any in-flight access from any state with no response.
REQ-029 SHALL hold req_ready=1 only after rst deasserts; during rst req_ready=0, resp_valid=0, mem_we=0, mem_a=0, mem_d=0.

Structure
REQ-030 SHALL place the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum in shared package lsu_pkg.
REQ-031 SHALL factor lane extract/extend and merge logic into combinational sub-module lsu_lane, instantiated once.

Verification
REQ-032 SHALL check word: store 0xDEADBEEF at 0x10, load word 0x10 -> resp_rdata 0xDEADBEEF 2 cycles after accept, mem_a=4.
REQ-033 SHALL check byte: with word 0x11223344 at 0x20, store byte 0xAA at 0x21 -> memory 0x11AA3344, resp 3 cycles after accept; signed byte load 0x21 -> 0xFFFFFFAA, unsigned -> 0x000000AA.
REQ-034 SHALL check half: with word 0x8001_7FFF at 0x30, signed half load 0x30 -> 0xFFFF8001; signed half load 0x32 -> 0x00007FFF.
REQ-035 SHALL check misalign: word store at 0x13 -> resp_misalign=1 after 1 cycle, mem_we never asserts, memory unchanged.
REQ-036 SHALL check reset: rst asserted during WRITE of store 0x5555AAAA -> mem_we=0 that cycle, no resp_valid, req_ready=1 the cycle after rst deasserts.
REQ-037 SHALL check back-to-back: req_valid held with two loads -> second accepted the cycle after first resp_valid, req_ready low between.
